// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: scanned 7-segment display bus plus the recovered-frame outputs.
//   master: display driver side, drives segment/bytee/colon and observes the frame outputs.
//   slave : decoder side, receives segment/bytee/colon and drives the frame outputs.
interface seg_scan_decoder_if;
  logic [6:0]  segment;
  logic [3:0]  bytee;
  logic        colon;
  logic [15:0] data_out;
  logic [3:0]  blank_out;
  logic [3:0]  err_out;
  logic        colon_out;
  logic        frame_valid;
  logic        frame_changed;
  modport master (
    output segment, bytee, colon,
    input  data_out, blank_out, err_out, colon_out, frame_valid, frame_changed
  );
  modport slave (
    input  segment, bytee, colon,
    output data_out, blank_out, err_out, colon_out, frame_valid, frame_changed
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the 4-digit hex value shown on a multiplexed 7-segment bus.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : slave modport; segment/bytee/colon in, data/blank/err/colon out, frame_valid/frame_changed pulses
module seg_scan_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic             clock,
  input logic             reset,
  seg_scan_decoder_if.slave bus
);
  localparam logic [1:0]  IDLE        = 2'd0;
  localparam logic [1:0]  SETTLE      = 2'd1;
  localparam logic [1:0]  HOLD        = 2'd2;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LOAD    = 16'(TIMEOUT_CYCLES);
  logic [6:0]  seg_s1_q, seg_s2_q, lseg_q, lseg_d, seg;
  logic [3:0]  dig_s1_q, dig_s2_q, lsel_q, lsel_d, dig;
  logic        col_s1_q, col_s2_q, col;
  logic [1:0]  state_q, state_d, idx;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d, shd_q, data_q, pub_data;
  logic [3:0]  blk_q, serr_q, seen_q, seen_d, blank_q, err_q, pub_blank, pub_err;
  logic        colacc_q, colacc_d, colon_q, fv_q, fc_q, have_q;
  logic        sel_ok, restart, sample, expire, publish, changed;
  logic [5:0]  dec;
  // {err, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 6'h00;
      7'h06: decode = 6'h01;
      7'h5B: decode = 6'h02;
      7'h4F: decode = 6'h03;
      7'h66: decode = 6'h04;
      7'h6D: decode = 6'h05;
      7'h7D: decode = 6'h06;
      7'h07: decode = 6'h07;
      7'h7F: decode = 6'h08;
      7'h6F: decode = 6'h09;
      7'h77: decode = 6'h0A;
      7'h7C: decode = 6'h0B;
      7'h39: decode = 6'h0C;
      7'h5E: decode = 6'h0D;
      7'h79: decode = 6'h0E;
      7'h71: decode = 6'h0F;
      7'h00: decode = 6'b01_0000;
      default: decode = 6'b10_1111;
    endcase
  endfunction
  assign seg    = seg_s2_q ^ {7{SEG_ACTIVE_LOW}};
  assign dig    = dig_s2_q ^ {4{DIG_ACTIVE_LOW}};
  assign col    = col_s2_q;
  assign sel_ok = (dig != 4'd0) && ((dig & (dig - 4'd1)) == 4'd0);
  assign idx    = lsel_q[3] ? 2'd3 : lsel_q[2] ? 2'd2 : lsel_q[1] ? 2'd1 : 2'd0;
  assign dec    = decode(lseg_q);
  always_comb begin
    // restart = re-latch the current select/segments and begin a fresh settle window
    restart   = (state_q == IDLE)   ? sel_ok :
                (state_q == SETTLE) ? (dig != lsel_q || seg != lseg_q) :
                (state_q == HOLD)   ? (dig != lsel_q) : 1'b1;
    sample    = !restart && state_q == SETTLE && cnt_q == SETTLE_LAST;
    state_d   = restart ? (sel_ok ? SETTLE : IDLE) : sample ? HOLD : state_q;
    lsel_d    = restart ? dig : lsel_q;
    lseg_d    = restart ? seg : lseg_q;
    cnt_d     = restart ? 8'd0 : (state_q == SETTLE && !sample) ? cnt_q + 8'd1 : cnt_q;
    // an expiry coinciding with a sample is deferred one cycle so the frame includes it
    expire    = seen_q != 4'h0 && tmo_q == 16'h0;
    publish   = seen_q == 4'hF || (expire && !sample);
    seen_d    = (publish ? 4'h0 : seen_q) | (sample ? 4'b0001 << idx : 4'h0);
    colacc_d  = (publish ? 1'b0 : colacc_q) | (sample & col);
    tmo_d     = ((sample && !expire) || publish) ? TMO_LOAD :
                (seen_q != 4'h0 && tmo_q != 16'h0) ? tmo_q - 16'd1 : tmo_q;
    pub_data  = shd_q & {{4{seen_q[3]}}, {4{seen_q[2]}}, {4{seen_q[1]}}, {4{seen_q[0]}}};
    pub_blank = blk_q | ~seen_q;
    pub_err   = serr_q & seen_q;
    changed   = !have_q || {pub_data, pub_blank, pub_err} != {data_q, blank_q, err_q};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
      col_s1_q <= 1'b0;
      col_s2_q <= 1'b0;
      state_q  <= IDLE;
      lsel_q   <= '0;
      lseg_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      shd_q    <= '0;
      blk_q    <= '0;
      serr_q   <= '0;
      seen_q   <= '0;
      colacc_q <= 1'b0;
      data_q   <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      colon_q  <= 1'b0;
      fv_q     <= 1'b0;
      fc_q     <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      seg_s1_q <= bus.segment;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= bus.bytee;
      dig_s2_q <= dig_s1_q;
      col_s1_q <= bus.colon;
      col_s2_q <= col_s1_q;
      state_q  <= state_d;
      lsel_q   <= lsel_d;
      lseg_q   <= lseg_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      colacc_q <= colacc_d;
      if (sample) begin
        shd_q[{idx, 2'b00} +: 4] <= dec[3:0];
        blk_q[idx]               <= dec[4];
        serr_q[idx]              <= dec[5];
      end
      if (publish) begin
        data_q  <= pub_data;
        blank_q <= pub_blank;
        err_q   <= pub_err;
        colon_q <= colacc_q;
        have_q  <= 1'b1;
      end
      fv_q <= publish;
      fc_q <= publish && changed;
    end
  end
  assign bus.data_out      = data_q;
  assign bus.blank_out     = blank_q;
  assign bus.err_out       = err_q;
  assign bus.colon_out     = colon_q;
  assign bus.frame_valid   = fv_q;
  assign bus.frame_changed = fc_q;
endmodule
